// File: rtl/game_pkg.sv
// Shared types and keycodes for the Pong game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    START  = 3'd0,
    PLAY   = 3'd1,
    PAUSE  = 3'd2,
    LVL_UP = 3'd3,
    OVER   = 3'd4,
    WIN    = 3'd5
  } gf_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

endpackage

// File: rtl/key_edge.sv
// Turns a level keycode into a single-cycle press pulse for one key.
module key_edge #(
  parameter logic [7:0] KEY = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press
);

  logic [7:0] key_prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) key_prev_q <= 8'h00;
    else       key_prev_q <= keycode;
  end

  // A held key matches on both sides, so only the first cycle counts.
  assign press = (keycode == KEY) && (key_prev_q != KEY);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: title, play, pause, level-up banner, game over and win,
// with lives, per-level score and banner frame counter.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_LEVELS    = 4,
  parameter int         LVL_W         = 3,
  parameter int         SCORE_W       = 4,
  parameter int         PTS_PER_LVL   = 5,
  parameter int         LIVES         = 3,
  parameter int         BANNER_FRAMES = 60,
  parameter logic [7:0] START_KEY     = KEY_SPACE,
  parameter logic [7:0] PAUSE_KEY     = KEY_P
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic               frame_tick,
  input  logic               point_won,
  input  logic               point_lost,
  output logic [LVL_W-1:0]   cur_lvl,
  output logic [2:0]         game_state,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_active,
  output logic               banner_on,
  output logic               game_over,
  output logic               game_won
);

  localparam int BCNT_W = $clog2(BANNER_FRAMES + 1);

  localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(NUM_LEVELS);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(PTS_PER_LVL - 1);
  localparam logic [SCORE_W-1:0] SCORE_FULL = SCORE_W'(PTS_PER_LVL);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [BCNT_W-1:0]  BCNT_LAST  = BCNT_W'(BANNER_FRAMES - 1);

  logic start_press;
  logic pause_press;

  key_edge #(.KEY(START_KEY)) u_start_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (start_press)
  );

  key_edge #(.KEY(PAUSE_KEY)) u_pause_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (pause_press)
  );

  gf_state_t          state_q, state_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= START;
      lvl_q   <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      score_q <= score_d;
      lives_q <= lives_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    score_d = score_q;
    lives_d = lives_q;
    bcnt_d  = bcnt_q;

    case (state_q)
      START: begin
        if (start_press) begin
          state_d = PLAY;
          lvl_d   = LVL_W'(1);
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      end

      // A miss outranks a simultaneous score, and any point event swallows a pause.
      PLAY: begin
        if (point_lost) begin
          if (lives_q <= 3'd1) begin
            state_d = OVER;
            lives_d = 3'd0;
          end else begin
            lives_d = lives_q - 3'd1;
          end
        end else if (point_won) begin
          if (score_q == SCORE_LAST) begin
            if (lvl_q == LVL_LAST) begin
              state_d = WIN;
              score_d = SCORE_FULL;
            end else begin
              state_d = LVL_UP;
              lvl_d   = lvl_q + LVL_W'(1);
              score_d = '0;
              bcnt_d  = '0;
            end
          end else begin
            score_d = score_q + SCORE_W'(1);
          end
        end else if (pause_press) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (pause_press) state_d = PLAY;
      end

      LVL_UP: begin
        if (frame_tick) begin
          if (bcnt_q == BCNT_LAST) begin
            state_d = PLAY;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end

      OVER, WIN: begin
        if (start_press) begin
          state_d = START;
          lvl_d   = '0;
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      end

      default: begin
        state_d = START;
        lvl_d   = '0;
        score_d = '0;
        lives_d = LIVES_INIT;
        bcnt_d  = '0;
      end
    endcase
  end

  assign cur_lvl     = lvl_q;
  assign game_state  = state_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_active = (state_q == PLAY);
  assign banner_on   = (state_q == LVL_UP);
  assign game_over   = (state_q == OVER);
  assign game_won    = (state_q == WIN);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a vector table plus multi-cycle sequences.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       point_won;
  logic       point_lost;
  logic [2:0] cur_lvl;
  logic [2:0] game_state;
  logic [3:0] score;
  logic [2:0] lives;
  logic       game_active;
  logic       banner_on;
  logic       game_over;
  logic       game_won;

  int n_cmp  = 0;
  int n_fail = 0;

  game_flow_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .frame_tick  (frame_tick),
    .point_won   (point_won),
    .point_lost  (point_lost),
    .cur_lvl     (cur_lvl),
    .game_state  (game_state),
    .score       (score),
    .lives       (lives),
    .game_active (game_active),
    .banner_on   (banner_on),
    .game_over   (game_over),
    .game_won    (game_won)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] kc;
    logic       ft;
    logic       pw;
    logic       pl;
    logic [2:0] st;
    logic [2:0] lvl;
    logic [3:0] sc;
    logic [2:0] lv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic [2:0] lvl,
                           input logic [3:0] sc, input logic [2:0] lv);
    chk({tag, ".state"},  32'(game_state),  32'(st));
    chk({tag, ".lvl"},    32'(cur_lvl),     32'(lvl));
    chk({tag, ".score"},  32'(score),       32'(sc));
    chk({tag, ".lives"},  32'(lives),       32'(lv));
    chk({tag, ".active"}, 32'(game_active), 32'(st == 3'(PLAY)));
    chk({tag, ".banner"}, 32'(banner_on),   32'(st == 3'(LVL_UP)));
    chk({tag, ".over"},   32'(game_over),   32'(st == 3'(OVER)));
    chk({tag, ".won"},    32'(game_won),    32'(st == 3'(WIN)));
  endtask

  task automatic step(input logic [7:0] kc, input logic ft, input logic pw, input logic pl);
    @(negedge Clk);
    keycode    = kc;
    frame_tick = ft;
    point_won  = pw;
    point_lost = pl;
    @(posedge Clk);
    #1;
  endtask

  // From LVL_UP: a point during the banner is ignored, then 60 ticks return to PLAY.
  task automatic run_banner(input logic [2:0] lvl);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    check_out($sformatf("banner%0d.pw", lvl), 3'(LVL_UP), lvl, 4'd0, 3'd3);
    for (int t = 1; t <= 60; t++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      if (t == 59) chk($sformatf("banner%0d.t59", lvl), 32'(game_state), 32'(LVL_UP));
      if (t == 60) check_out($sformatf("banner%0d.t60", lvl), 3'(PLAY), lvl, 4'd0, 3'd3);
    end
  endtask

  task automatic clear_level(input logic [2:0] lvl, input logic [2:0] nxt_st,
                             input logic [2:0] nxt_lvl, input logic [3:0] nxt_sc);
    for (int p = 1; p <= 5; p++) begin
      step(8'h00, 1'b0, 1'b1, 1'b0);
      if (p < 5) chk($sformatf("lvl%0d.score%0d", lvl, p), 32'(score), 32'(p));
    end
    check_out($sformatf("lvl%0d.clear", lvl), nxt_st, nxt_lvl, nxt_sc, 3'd3);
  endtask

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{8'h2C, 0, 0, 0, 3'(PLAY),  3'd1, 4'd0, 3'd3};
    vecs[1]  = '{8'h2C, 0, 0, 0, 3'(PLAY),  3'd1, 4'd0, 3'd3};
    vecs[2]  = '{8'h2C, 0, 0, 0, 3'(PLAY),  3'd1, 4'd0, 3'd3};
    vecs[3]  = '{8'h00, 0, 1, 0, 3'(PLAY),  3'd1, 4'd1, 3'd3};
    vecs[4]  = '{8'h00, 0, 0, 1, 3'(PLAY),  3'd1, 4'd1, 3'd2};
    vecs[5]  = '{8'h00, 0, 1, 1, 3'(PLAY),  3'd1, 4'd1, 3'd1};
    vecs[6]  = '{8'h13, 0, 0, 0, 3'(PAUSE), 3'd1, 4'd1, 3'd1};
    vecs[7]  = '{8'h13, 0, 0, 1, 3'(PAUSE), 3'd1, 4'd1, 3'd1};
    vecs[8]  = '{8'h00, 0, 1, 0, 3'(PAUSE), 3'd1, 4'd1, 3'd1};
    vecs[9]  = '{8'h13, 0, 0, 0, 3'(PLAY),  3'd1, 4'd1, 3'd1};
    vecs[10] = '{8'h00, 0, 0, 0, 3'(PLAY),  3'd1, 4'd1, 3'd1};
    vecs[11] = '{8'h13, 0, 1, 0, 3'(PLAY),  3'd1, 4'd2, 3'd1};
    vecs[12] = '{8'h13, 0, 0, 0, 3'(PLAY),  3'd1, 4'd2, 3'd1};
    vecs[13] = '{8'h2C, 0, 0, 0, 3'(PLAY),  3'd1, 4'd2, 3'd1};
    vecs[14] = '{8'h00, 0, 1, 1, 3'(OVER),  3'd1, 4'd2, 3'd0};
    vecs[15] = '{8'h00, 0, 0, 1, 3'(OVER),  3'd1, 4'd2, 3'd0};
    vecs[16] = '{8'h13, 0, 1, 0, 3'(OVER),  3'd1, 4'd2, 3'd0};
    vecs[17] = '{8'h2C, 0, 0, 0, 3'(START), 3'd0, 4'd0, 3'd3};
    vecs[18] = '{8'h2C, 0, 0, 0, 3'(START), 3'd0, 4'd0, 3'd3};
    vecs[19] = '{8'h00, 0, 1, 0, 3'(START), 3'd0, 4'd0, 3'd3};
    vecs[20] = '{8'h13, 0, 0, 0, 3'(START), 3'd0, 4'd0, 3'd3};
    vecs[21] = '{8'h2C, 0, 0, 0, 3'(PLAY),  3'd1, 4'd0, 3'd3};

    Reset      = 1'b1;
    keycode    = 8'h00;
    frame_tick = 1'b0;
    point_won  = 1'b0;
    point_lost = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_out("reset", 3'(START), 3'd0, 4'd0, 3'd3);
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].kc, vecs[i].ft, vecs[i].pw, vecs[i].pl);
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].sc, vecs[i].lv);
    end

    // Full run to WIN with the banner between levels.
    clear_level(3'd1, 3'(LVL_UP), 3'd2, 4'd0);
    run_banner(3'd2);
    clear_level(3'd2, 3'(LVL_UP), 3'd3, 4'd0);
    run_banner(3'd3);
    clear_level(3'd3, 3'(LVL_UP), 3'd4, 4'd0);
    run_banner(3'd4);
    clear_level(3'd4, 3'(WIN), 3'd4, 4'd5);
    step(8'h00, 1'b0, 1'b1, 1'b1);
    check_out("win.hold", 3'(WIN), 3'd4, 4'd5, 3'd3);
    step(8'h2C, 1'b0, 1'b0, 1'b0);
    check_out("win.restart", 3'(START), 3'd0, 4'd0, 3'd3);

    // Asynchronous reset in the middle of a level-up banner.
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h2C, 1'b0, 1'b0, 1'b0);
    check_out("ar.play", 3'(PLAY), 3'd1, 4'd0, 3'd3);
    step(8'h2C, 1'b0, 1'b0, 1'b1);
    repeat (5) step(8'h2C, 1'b0, 1'b1, 1'b0);
    step(8'h2C, 1'b1, 1'b0, 1'b0);
    check_out("ar.lvlup", 3'(LVL_UP), 3'd2, 4'd0, 3'd2);
    point_won = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    check_out("ar.async", 3'(START), 3'd0, 4'd0, 3'd3);
    @(posedge Clk);
    #1;
    check_out("ar.held", 3'(START), 3'd0, 4'd0, 3'd3);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_out("ar.release", 3'(PLAY), 3'd1, 4'd0, 3'd3);
    step(8'h2C, 1'b0, 1'b0, 1'b0);
    check_out("ar.hold", 3'(PLAY), 3'd1, 4'd0, 3'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
